// File: rtl/logic_fnct_seq.sv
// ---------------------------------------------------------------------------
// logic_fnct_seq : key debouncer, vector sequencer and self-checker for the
// two-input logic-function LED unit. Option: LOGIC_FNCT_SEQ_STATUS_LED_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module logic_fnct_seq #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_n,
  input  logic       start,
  input  logic [9:0] fn_led,
  output logic [1:0] fn_key,
  output logic [9:0] led,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW  = $clog2(SETTLE_CYCLES) + 1;
  localparam int HW  = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [9:0] expected_led(input logic [1:0] v);
    case (v)
      2'd0:    expected_led = 10'h3E4;
      2'd1:    expected_led = 10'h0DA;
      2'd2:    expected_led = 10'h0FE;
      default: expected_led = 10'h003;
    endcase
  endfunction

  // Key path: 2-flop synchronizer, then per-bit debounce counter
  logic [1:0] sync1_q, sync2_q, deb_q, deb_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [DBW-1:0] cnt_q, cnt_d;
    logic           bit_d;

    always_comb begin
      cnt_d = '0;
      bit_d = deb_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
          bit_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign deb_d[i] = bit_d;
  end

  // Sequencer
  state_t        state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [3:0]    mask_q, mask_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [HW-1:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= 2'd0;
      mask_q   <= 4'd0;
      settle_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = 2'd0;
          mask_d  = 4'd0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        settle_d = SW'(SETTLE_CYCLES);
        state_d  = S_SETTLE;
      end
      // Leave on the cycle the counter reaches 0 so SETTLE lasts SETTLE_CYCLES
      S_SETTLE: begin
        if (settle_q <= SW'(1)) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (fn_led != expected_led(vec_q)) mask_d[vec_q] = 1'b1;
        hold_d  = HW'(HOLD_CYCLES);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q <= HW'(1)) begin
          hold_d = '0;
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = S_APPLY;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                     (state_q == S_CHECK) || (state_q == S_HOLD);
  assign pass      = (state_q == S_DONE) && ~|mask_q;
  assign fail      = (state_q == S_DONE) &&  |mask_q;
  assign fail_mask = mask_q;
  assign vec_idx   = vec_q;
  assign fn_key    = busy ? ~vec_q : deb_q;

`ifdef LOGIC_FNCT_SEQ_STATUS_LED_EN
  // Status shown once on entering DONE; any debounced key change or start drops it
  logic status_q, status_d;

  always_comb begin
    status_d = status_q;
    if ((deb_d != deb_q) || start) status_d = 1'b0;
    if ((state_q == S_HOLD) && (state_d == S_DONE)) status_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) status_q <= 1'b0;
    else        status_q <= status_d;
  end

  always_comb begin
    led = fn_led;
    if ((state_q == S_DONE) && status_q) begin
      led = pass ? 10'h3FF : {6'b0, mask_q};
    end
  end
`else
  assign led = fn_led;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_fnct_seq.sv
// Directed bench for logic_fnct_seq with a behavioral function unit that can
// have LED bit 4 stuck at 0.
`default_nettype none

module tb_logic_fnct_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic       start;
  logic [9:0] fn_led;
  logic [1:0] fn_key;
  logic [9:0] led;
  logic       busy, pass, fail;
  logic [3:0] fail_mask;
  logic [1:0] vec_idx;
  logic       fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_fnct_seq #(
    .DEBOUNCE_CYCLES(8),
    .SETTLE_CYCLES  (2),
    .HOLD_CYCLES    (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .start    (start),
    .fn_led   (fn_led),
    .fn_key   (fn_key),
    .led      (led),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .fail_mask(fail_mask),
    .vec_idx  (vec_idx)
  );

  // Behavioral function unit driven by the active-low keys
  always_comb begin
    case (~fn_key)
      2'd0:    fn_led = 10'h3E4;
      2'd1:    fn_led = 10'h0DA;
      2'd2:    fn_led = 10'h0FE;
      default: fn_led = 10'h003;
    endcase
    if (fault) fn_led[4] = 1'b0;
  end

`ifdef LOGIC_FNCT_SEQ_STATUS_LED_EN
  localparam logic [9:0] LED_PASS = 10'h3FF;
  localparam logic [9:0] LED_FAIL = 10'h006;
`else
  localparam logic [9:0] LED_PASS = 10'h3E4;
  localparam logic [9:0] LED_FAIL = 10'h3E4;
`endif

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_n = 2'b00; start = 1'b0; fault = 1'b0;
    step(2);
    total += 6;
    if (fn_key !== 2'b11) begin bad++; $display("FAIL reset_fn_key got=%b exp=11", fn_key); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
    if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
    if (fail_mask !== 4'b0) begin bad++; $display("FAIL reset_mask got=%b exp=0000", fail_mask); end
    if (vec_idx !== 2'd0) begin bad++; $display("FAIL reset_vec got=%0d exp=0", vec_idx); end
    key_n = 2'b11;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_debounce();
    // three-cycle bounce on key 0, then stable low
    key_n[0] = 1'b0; step(1);
    key_n[0] = 1'b1; step(1);
    key_n[0] = 1'b0;
    step(9);
    total++;
    if (fn_key[0] !== 1'b1) begin bad++; $display("FAIL deb_early got=%b exp=1", fn_key[0]); end
    step(1);
    total++;
    if (fn_key[0] !== 1'b0) begin bad++; $display("FAIL deb_fall got=%b exp=0", fn_key[0]); end
    // 5-cycle glitch on key 1 must not pass
    key_n[1] = 1'b0; step(5);
    key_n[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      total++;
      if (fn_key[1] !== 1'b1) begin bad++; $display("FAIL deb_short cyc=%0d got=%b exp=1", i, fn_key[1]); end
    end
    key_n[0] = 1'b1;
    step(12);
    total += 2;
    if (fn_key !== 2'b11) begin bad++; $display("FAIL deb_release got=%b exp=11", fn_key); end
    if (led !== 10'h3E4) begin bad++; $display("FAIL idle_led got=%h exp=3e4", led); end
  endtask

  task automatic test_good_sweep();
    logic [1:0] v;
    pulse_start();
    for (int k = 1; k <= 28; k++) begin
      v = 2'((k - 1) / 7);
      total += 3;
      if (busy !== 1'b1) begin bad++; $display("FAIL good_busy k=%0d got=%b exp=1", k, busy); end
      if (vec_idx !== v) begin bad++; $display("FAIL good_vec k=%0d got=%0d exp=%0d", k, vec_idx, v); end
      if (fn_key !== ~v) begin bad++; $display("FAIL good_fn_key k=%0d got=%b exp=%b", k, fn_key, ~v); end
      step(1);
    end
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL good_done_busy got=%b exp=0", busy); end
    if (pass !== 1'b1) begin bad++; $display("FAIL good_pass got=%b exp=1", pass); end
    if (fail !== 1'b0) begin bad++; $display("FAIL good_fail got=%b exp=0", fail); end
    if (fail_mask !== 4'b0000) begin bad++; $display("FAIL good_mask got=%b exp=0000", fail_mask); end
    if (vec_idx !== 2'd3) begin bad++; $display("FAIL good_vec_end got=%0d exp=3", vec_idx); end
    if (led !== LED_PASS) begin bad++; $display("FAIL good_led got=%h exp=%h", led, LED_PASS); end
  endtask

  task automatic test_faulty_unit();
    fault = 1'b1;
    pulse_start();
    step(28);
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL fault_busy got=%b exp=0", busy); end
    if (pass !== 1'b0) begin bad++; $display("FAIL fault_pass got=%b exp=0", pass); end
    if (fail !== 1'b1) begin bad++; $display("FAIL fault_fail got=%b exp=1", fail); end
    if (fail_mask !== 4'b0110) begin bad++; $display("FAIL fault_mask got=%b exp=0110", fail_mask); end
    if (led !== LED_FAIL) begin bad++; $display("FAIL fault_led got=%h exp=%h", led, LED_FAIL); end
    fault = 1'b0;
  endtask

  task automatic test_start_in_hold();
    pulse_start();
    total += 2;
    if (fail_mask !== 4'b0000) begin bad++; $display("FAIL rearm_mask got=%b exp=0000", fail_mask); end
    if (fail !== 1'b0) begin bad++; $display("FAIL rearm_fail got=%b exp=0", fail); end
    step(11);
    total++;
    if (vec_idx !== 2'd1) begin bad++; $display("FAIL hold_vec got=%0d exp=1", vec_idx); end
    pulse_start();
    step(15);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL hold_last_busy got=%b exp=1", busy); end
    step(1);
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_done_busy got=%b exp=0", busy); end
    if (vec_idx !== 2'd3) begin bad++; $display("FAIL hold_vec_end got=%0d exp=3", vec_idx); end
    if (pass !== 1'b1) begin bad++; $display("FAIL hold_pass got=%b exp=1", pass); end
  endtask

  task automatic test_reset_mid_sweep();
    fault = 1'b1;
    pulse_start();
    step(16);
    total += 3;
    if (vec_idx !== 2'd2) begin bad++; $display("FAIL mid_vec got=%0d exp=2", vec_idx); end
    if (fail_mask !== 4'b0010) begin bad++; $display("FAIL mid_mask got=%b exp=0010", fail_mask); end
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    total += 6;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (fail_mask !== 4'b0000) begin bad++; $display("FAIL rst_mask got=%b exp=0000", fail_mask); end
    if (vec_idx !== 2'd0) begin bad++; $display("FAIL rst_vec got=%0d exp=0", vec_idx); end
    if (fn_key !== 2'b11) begin bad++; $display("FAIL rst_fn_key got=%b exp=11", fn_key); end
    if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%b exp=0", pass); end
    if (fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%b exp=0", fail); end
    rst_n = 1'b1;
    step(2);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy got=%b exp=0", busy); end
    fault = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_good_sweep();
    test_faulty_unit();
    test_start_in_hold();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
